fast_pulse_tx: RTL

Source end of the req/ack pulse-crossing protocol: converts single-cycle event pulses in the `clk` domain into a four-phase level handshake (`req` out, `ack_async` back) that a receiver in any other clock domain can sample safely. It complements the slow-to-fast path by covering crossings where the destination clock is slower or unrelated. Pulses that arrive while a handshake is in flight are counted and replayed, so no event is lost until the counter saturates.

---
 rtl/fast_pulse_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/fast_pulse_tx.sv
// Source side of a req/ack pulse crossing: clk-domain event pulses become four-phase
// level handshakes, with a saturating backlog counter. Option macro: FAST_PULSE_TX_EDGE_IN_EN.
module fast_pulse_tx #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_async,
  input  logic             clr_ovf,
  output logic             req,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             sent_pulse,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  // Handshake: req rises to start a transfer and holds until ack_s is seen high;
  // the transfer completes when ack_s returns low, at which point sent_pulse strobes.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   ev;
  logic                   inc;
  logic                   ovf_set;
  logic [CNT_W-1:0]       pend_nxt;

  always_ff @(posedge clk) begin
    if (rst) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_async};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef FAST_PULSE_TX_EDGE_IN_EN
  logic pulse_q;
  logic ev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      pulse_q <= pulse_in;
      ev_q    <= pulse_in & ~pulse_q;
    end
  end
  assign ev = ev_q;
`else
  assign ev = pulse_in;
`endif

  always_comb begin
    state_nxt  = state;
    pend_nxt   = pending;
    inc        = 1'b0;
    ovf_set    = 1'b0;
    sent_pulse = 1'b0;
    case (state)
      IDLE: if (ev) state_nxt = REQ;
      REQ: begin
        inc = ev;
        if (ack_s) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (ack_s) begin
          inc = ev;
        end else begin
          sent_pulse = 1'b1;
          if (pending != '0) begin
            // launching one queued event while a new one arrives is a net zero
            state_nxt = REQ;
            if (!ev) pend_nxt = pending - 1'b1;
          end else if (ev) begin
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (inc) begin
      if (pending == CNT_MAX) ovf_set = 1'b1;
      else                    pend_nxt = pending + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      req     <= (state_nxt == REQ);
      busy    <= (state_nxt != IDLE);
      pending <= pend_nxt;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign state_dbg = state;

endmodule
